// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory and decode handshake bundle for fetch_sequencer
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [15:0] br_offset;
   logic [25:0] jump_addr;
   logic        fault;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, fault,
      input  imem_ack, imem_data, instr_ready, branch, zero, jump, br_offset, jump_addr
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, fault,
      output imem_ack, imem_data, instr_ready, branch, zero, jump, br_offset, jump_addr
   );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-outstanding instruction fetch FSM with branch/jump redirect
// Define FETCH_TIMEOUT_EN to enable the fetch timeout counter, sticky fault and HALT state.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] instr_q, instr_nxt;
   logic [31:0] instr_pc_q, instr_pc_nxt;
   logic [31:0] seq_pc, redirect_pc;
   logic        timeout_hit;

   // Taken branch wins over jump; a branch without zero falls through to jump/seq.
   assign seq_pc = instr_pc_q + 32'd1;
   always_comb begin
      redirect_pc = seq_pc;
      if (bus.branch && bus.zero)
         redirect_pc = seq_pc + {{16{bus.br_offset[15]}}, bus.br_offset};
      else if (bus.jump)
         redirect_pc = {seq_pc[31:26], bus.jump_addr};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         instr_q    <= instr_nxt;
         instr_pc_q <= instr_pc_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      instr_nxt    = instr_q;
      instr_pc_nxt = instr_pc_q;
      case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            if (bus.imem_ack) begin
               instr_nxt    = bus.imem_data;
               instr_pc_nxt = pc;
               state_nxt    = HOLD;
            end else if (timeout_hit) begin
               state_nxt = HALT;
            end
         end
         HOLD: begin
            if (bus.instr_ready) begin
               pc_nxt    = redirect_pc;
               state_nxt = REQ;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.imem_req    = (state == REQ);
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = (state == HOLD);
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;

`ifdef FETCH_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TCW-1:0] tcnt, tcnt_nxt;
   logic           fault_q;

   // The last tolerated unacknowledged REQ cycle is the one where the count reaches TIMEOUT_CYCLES-1.
   assign timeout_hit = (tcnt == TCW'(TIMEOUT_CYCLES - 1));
   assign tcnt_nxt    = (state == REQ && !bus.imem_ack) ? tcnt + TCW'(1) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt    <= '0;
         fault_q <= 1'b0;
      end else begin
         tcnt    <= tcnt_nxt;
         fault_q <= fault_q | (state_nxt == HALT);
      end
   end

   assign bus.fault = fault_q;
`else
   logic [31:0] unused_timeout_cycles;

   assign unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_hit           = 1'b0;
   assign bus.fault             = 1'b0;
`endif
endmodule
